// File: rtl/factor_scan.sv
// factor_scan: cycle-stepped factoring controller for an external combinational multiplier.
// Walks candidate pairs (a, b) with 2 <= a <= b <= max in a-major order, one per cycle. The
// first pair whose product equals the latched target is reported.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, target    begin a scan (sampled only when idle); number to factor
//   multiplicand     candidate a, driven to the multiplier (the a counter register)
//   multiplier       candidate b, driven to the multiplier (the b counter register)
//   product          combinational a*b returned by the multiplier
//   busy             high while scanning
//   done             one-cycle pulse when a scan ends
//   found            last scan found a pair; held until the next accepted start
//   factor_a/_b      the pair found (a <= b); held
module factor_scan #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PWIDTH-1:0] target,
  output logic [WIDTH-1:0]  multiplicand,
  output logic [WIDTH-1:0]  multiplier,
  input  logic [PWIDTH-1:0] product,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WIDTH-1:0]  factor_a,
  output logic [WIDTH-1:0]  factor_b
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [WIDTH-1:0] MaxVal   = '1;
  localparam logic [WIDTH-1:0] FirstVal = WIDTH'(2);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PWIDTH-1:0] tgt_q, tgt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fb_q, fb_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tgt_d   = target;
          a_d     = FirstVal;
          b_d     = FirstVal;
          found_d = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        // product is the multiplier's response to the a/b registers in this same cycle
        if (product == tgt_q) begin
          found_d = 1'b1;
          fa_d    = a_q;
          fb_d    = b_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (b_q != MaxVal) begin
          b_d = b_q + WIDTH'(1);
        end else if (a_q != MaxVal) begin
          // b restarts at the new a so only pairs with a <= b are visited
          a_d = a_q + WIDTH'(1);
          b_d = a_q + WIDTH'(1);
        end else begin
          found_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign multiplicand = a_q;
  assign multiplier   = b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign found        = found_q;
  assign factor_a     = fa_q;
  assign factor_b     = fb_q;

endmodule

// File: tb/tb_factor_scan.sv
// Directed bench for factor_scan with a behavioural 3x3 multiplier in the loop.
module tb_factor_scan;

  localparam int W  = 3;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] target;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;
  logic          found;
  logic [W-1:0]  factor_a;
  logic [W-1:0]  factor_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign product = {3'b000, multiplicand} * {3'b000, multiplier};

  factor_scan #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .target       (target),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .factor_a     (factor_a),
    .factor_b     (factor_b)
  );

  typedef struct {
    int tgt;
    int exp_found;
    int exp_a;
    int exp_b;
    int exp_k;
    bit perturb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one scan and follow it to its done pulse, checking visit order on the way.
  task automatic run_scan(input vec_t v);
    int cycles   = 0;
    int order_ok = 1;
    int ea       = 2;
    int eb       = 2;
    bit seen     = 0;
    @(negedge clk);
    start  = 1'b1;
    target = PW'(v.tgt);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_start t=%0d", v.tgt), int'(busy), 1);
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) begin
        cycles++;
        if (int'(multiplicand) != ea || int'(multiplier) != eb) order_ok = 0;
        if (eb != 7) eb++;
        else begin
          ea++;
          eb = ea;
        end
        if (v.perturb && cycles == 2) begin
          target = PW'(35);
          start  = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("done_seen t=%0d", v.tgt), int'(seen), 1);
    check($sformatf("busy_cycles t=%0d", v.tgt), cycles, v.exp_k);
    check($sformatf("pair_order t=%0d", v.tgt), order_ok, 1);
    check($sformatf("busy_at_done t=%0d", v.tgt), int'(busy), 0);
    check($sformatf("found t=%0d", v.tgt), int'(found), v.exp_found);
    check($sformatf("factor_a t=%0d", v.tgt), int'(factor_a), v.exp_a);
    check($sformatf("factor_b t=%0d", v.tgt), int'(factor_b), v.exp_b);
    @(negedge clk);
    check($sformatf("done_one_cycle t=%0d", v.tgt), int'(done), 0);
    check($sformatf("found_held t=%0d", v.tgt), int'(found), v.exp_found);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_fa"}, int'(factor_a), 0);
    check({tag, "_fb"}, int'(factor_b), 0);
    check({tag, "_a"}, int'(multiplicand), 0);
    check({tag, "_b"}, int'(multiplier), 0);
  endtask

  initial begin
    vecs[0] = '{tgt: 15, exp_found: 1, exp_a: 3, exp_b: 5, exp_k: 9,  perturb: 0};
    vecs[1] = '{tgt: 4,  exp_found: 1, exp_a: 2, exp_b: 2, exp_k: 1,  perturb: 0};
    vecs[2] = '{tgt: 49, exp_found: 1, exp_a: 7, exp_b: 7, exp_k: 21, perturb: 0};
    vecs[3] = '{tgt: 13, exp_found: 0, exp_a: 0, exp_b: 0, exp_k: 21, perturb: 0};
    vecs[4] = '{tgt: 1,  exp_found: 0, exp_a: 0, exp_b: 0, exp_k: 21, perturb: 0};
    vecs[5] = '{tgt: 12, exp_found: 1, exp_a: 2, exp_b: 6, exp_k: 5,  perturb: 1};
    vecs[6] = '{tgt: 0,  exp_found: 0, exp_a: 0, exp_b: 0, exp_k: 21, perturb: 0};
    vecs[7] = '{tgt: 63, exp_found: 0, exp_a: 0, exp_b: 0, exp_k: 21, perturb: 0};
    vecs[8] = '{tgt: 22, exp_found: 0, exp_a: 0, exp_b: 0, exp_k: 21, perturb: 0};

    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_start_busy", int'(busy), 0);

    foreach (vecs[i]) run_scan(vecs[i]);

    // Reset in the 5th scan cycle of target=42 aborts with no done pulse.
    @(negedge clk);
    start  = 1'b1;
    target = PW'(42);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_reset_pre_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_reset");
    @(negedge clk);
    check("after_reset_idle", int'(busy), 0);
    run_scan('{tgt: 42, exp_found: 1, exp_a: 6, exp_b: 7, exp_k: 20, perturb: 0});

    // start held high: busy, busy, done repeating with no extra idle cycle.
    @(negedge clk);
    start  = 1'b1;
    target = PW'(6);
    @(negedge clk);
    for (int c = 0; c < 9; c++) begin
      check($sformatf("b2b_busy c=%0d", c), int'(busy), (c % 3 != 2) ? 1 : 0);
      check($sformatf("b2b_done c=%0d", c), int'(done), (c % 3 == 2) ? 1 : 0);
      if (c % 3 == 2) begin
        check($sformatf("b2b_found c=%0d", c), int'(found), 1);
        check($sformatf("b2b_fa c=%0d", c), int'(factor_a), 2);
        check($sformatf("b2b_fb c=%0d", c), int'(factor_b), 3);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
